// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side handshake and control bus for the PC generator.
// master: the PC generator (drives pc, pc_valid and status).
// slave:  the fetch/control side (drives handshake, redirects, traps, RAS hints).
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             fetch_ready;
    logic             pc_valid;
    logic [WIDTH-1:0] pc;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             trap_valid;
    logic [WIDTH-1:0] trap_vector;
    logic             call_push;
    logic             ret_pop;
    logic             misaligned;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        input  stall,
        input  fetch_ready,
        output pc_valid,
        output pc,
        input  redirect_valid,
        input  redirect_target,
        input  trap_valid,
        input  trap_vector,
        input  call_push,
        input  ret_pop,
        output misaligned,
        output ras_empty,
        output ras_full
    );

    modport slave (
        output stall,
        output fetch_ready,
        input  pc_valid,
        input  pc,
        output redirect_valid,
        output redirect_target,
        output trap_valid,
        output trap_vector,
        output call_push,
        output ret_pop,
        input  misaligned,
        input  ras_empty,
        input  ras_full
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with trap/redirect steering and an
// optional return-address stack.
// Optional feature macro: PC_GEN_RAS_EN (defined -> return-address stack built;
// undefined -> call_push/ret_pop ignored, ras_empty=1, ras_full=0).
// Reset is synchronous, active-low (rst_n). All outputs come from registers.
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h8000_0000),
    parameter int               INSTR_BYTES  = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_gen_if.master  bus
);
    // Targets are forced onto an instruction boundary by clearing these bits.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INSTR_BYTES - 1));
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);

    logic [WIDTH-1:0] pc_q;
    logic             valid_q;
    logic             mis_q;

    logic [WIDTH-1:0] pc_nxt;
    logic             mis_nxt;
    logic [WIDTH-1:0] seq_pc;
    logic             fire;

    logic             ras_pop_ok;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty_w;
    logic             ras_full_w;

    assign fire   = valid_q & bus.fetch_ready & ~bus.stall;
    assign seq_pc = pc_q + STEP;

`ifdef PC_GEN_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    // Circular buffer: top_q points at the newest entry; when full, the next
    // push lands on the oldest slot, which is exactly the entry to discard.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ras_op_en;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] push_idx;

    assign ras_empty_w = (cnt_q == '0);
    assign ras_full_w  = (cnt_q == CNT_W'(RAS_DEPTH));
    // Trap and redirect win the next-pc choice, so the stack must not move.
    assign ras_op_en   = ~bus.trap_valid & ~bus.redirect_valid;
    assign push        = ras_op_en & fire & bus.call_push;
    assign pop         = ras_op_en & fire & bus.ret_pop & ~ras_empty_w;
    assign ras_top     = ras_mem[top_q];
    assign ras_pop_ok  = pop;
    // Push+pop replaces the top in place; a plain push opens a new slot.
    assign push_idx    = pop ? top_q : top_q + PTR_W'(1);

    // Stack pointer and occupancy; trap flushes, count saturates when full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_q <= '0;
            cnt_q <= '0;
        end else if (bus.trap_valid) begin
            cnt_q <= '0;
        end else if (push && !pop) begin
            top_q <= top_q + PTR_W'(1);
            if (!ras_full_w) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop && !push) begin
            top_q <= top_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Return-address storage; contents need no reset since count gates use.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            ras_mem[push_idx] <= seq_pc;
        end
    end
`else
    logic unused_ras;

    assign ras_empty_w = 1'b1;
    assign ras_full_w  = 1'b0;
    assign ras_top     = '0;
    assign ras_pop_ok  = 1'b0;
    assign unused_ras  = ^{bus.call_push, bus.ret_pop};
`endif

    // Next-pc selection: trap > redirect > return pop > sequential > hold.
    always_comb begin
        pc_nxt  = pc_q;
        mis_nxt = 1'b0;
        if (bus.trap_valid) begin
            pc_nxt  = bus.trap_vector & ALIGN_MASK;
            mis_nxt = |(bus.trap_vector & ~ALIGN_MASK);
        end else if (bus.redirect_valid) begin
            pc_nxt  = bus.redirect_target & ALIGN_MASK;
            mis_nxt = |(bus.redirect_target & ~ALIGN_MASK);
        end else if (ras_pop_ok) begin
            pc_nxt  = ras_top;
        end else if (fire) begin
            pc_nxt  = seq_pc;
        end
    end

    // PC, valid and misaligned-pulse registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            valid_q <= 1'b1;
            mis_q   <= mis_nxt;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = valid_q;
    assign bus.misaligned = mis_q;
    assign bus.ras_empty  = ras_empty_w;
    assign bus.ras_full   = ras_full_w;
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h80000000: PC value after reset.
REQ-003 Parameter INSTR_BYTES, default 4: sequential increment; power of two.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, ≥2.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 stall  in  1  freezes sequential/RAS advance.
REQ-008 fetch_ready  in  1  consumer accepts pc this cycle.
REQ-009 pc_valid  out  1  pc is presentable to fetch.
REQ-010 pc  out  WIDTH  current fetch address.
REQ-011 redirect_valid  in  1  branch/jump resolved taken.
REQ-012 redirect_target  in  WIDTH  redirect destination.
REQ-013 trap_valid  in  1  exception/interrupt entry.
REQ-014 trap_vector  in  WIDTH  trap destination.
REQ-015 call_push  in  1  instruction at pc is a call.
REQ-016 ret_pop  in  1  instruction at pc is a return.
REQ-017 misaligned  out  1  one-cycle pulse: last loaded target had nonzero low bits.
REQ-018 ras_empty  out  1  stack holds no entries.
REQ-019 ras_full  out  1  stack holds RAS_DEPTH entries.

Function
REQ-020 fire = pc_valid & fetch_ready & ~stall; sequential and RAS updates occur only on fire.
REQ-021 Next-PC priority per cycle: trap_valid > redirect_valid > (fire & ret_pop & ~ras_empty) > (fire: pc+INSTR_BYTES) > hold.
REQ-022 trap and redirect load on the next edge regardless of fire, stall or fetch_ready.
REQ-023 Loaded trap/redirect targets have the low log2(INSTR_BYTES) bits cleared; misaligned pulses high the following cycle iff those bits were nonzero.
REQ-024 While pc_valid & ~fetch_ready with no trap/redirect, pc holds stable.
REQ-025 Sequential increment is modulo 2^WIDTH; pc = 2^WIDTH-INSTR_BYTES wraps to 0.
REQ-026 pc_valid deasserts during reset; asserts the first cycle after rst_n rises and stays high thereafter.
REQ-027 Push on fire & call_push: write pc+INSTR_BYTES (modulo 2^WIDTH) at top; when full, overwrite oldest entry, count saturates at RAS_DEPTH.
REQ-028 Pop on fire & ret_pop & ~ras_empty: next pc = top entry, count decrements; pop when empty has no effect, pc advances sequentially.
REQ-029 Simultaneous push and pop on one fire: next pc = old top; top replaced by pc+INSTR_BYTES; count unchanged.
REQ-030 trap_valid clears the RAS (count = 0) on the same edge; redirect_valid leaves the RAS untouched.
REQ-031 Outputs register-driven; no combinational path from any input to pc or pc_valid.

Reset
REQ-032 On edge with rst_n = 0: pc = RESET_VECTOR, pc_valid = 0, misaligned = 0, RAS count = 0 (ras_empty = 1, ras_full = 0).
REQ-033 Reset overrides trap, redirect and RAS operations on the same edge, including mid-handshake.

Configuration
REQ-034 Macro PC_GEN_RAS_EN defined: RAS built per REQ-027..030.
REQ-035 Macro PC_GEN_RAS_EN undefined: no RAS storage; call_push and ret_pop ignored; ras_empty tied 1, ras_full tied 0; all other behaviour identical.

Verification
REQ-036 Reset release, fetch_ready = 1 for 3 cycles -> pc 80000000, 80000004, 80000008, 8000000C; pc_valid 0 in reset, 1 from first post-reset cycle.
REQ-037 pc = 80000010, fetch_ready = 0 for 2 cycles then redirect_valid with target 80000102 -> pc holds 80000010, then 80000100, misaligned = 1 one cycle.
REQ-038 Same cycle trap_valid (vector 00000200) and redirect_valid (target 80000400) -> pc = 00000200, ras_empty = 1.
REQ-039 (RAS_EN) calls at 80000000, 80000010 then returns -> pops 80000014, 80000004; fifth push at depth 4 -> ras_full stays 1, oldest lost; pop on empty -> sequential.
REQ-040 pc = FFFFFFFC, fire -> pc = 00000000; stall = 1 with fetch_ready = 1 -> pc holds.
REQ-041 rst_n = 0 asserted mid-stall with RAS holding 2 entries -> next cycle pc = 80000000, pc_valid = 0, ras_empty = 1.
